// File: rtl/riscv_defs.sv
// Shared RV32I control encodings: opcodes, datapath select codes and the
// multicycle controller state encoding. alu_decoder reuses the ALUOp values.
package riscv_defs;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

endpackage

// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM (lw, sw, R, I-ALU, beq, jal): sequences
// fetch/decode/execute/writeback and counts retired instructions.
module main_fsm
  import riscv_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             pc_write,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       dbg_state
);

  // Handshake: mem_ready is a single-cycle "access completes now" strobe,
  // honoured only in FETCH, MEMREAD and MEMWRITE; elsewhere it is ignored.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             pc_update, branch, retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ALUOp      = ALUOP_ADD;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ResultSrc  = RES_ALUOUT;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    illegal_op = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write strobe stays up for the whole wait so the memory sees a stable request.
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    pc_write = pc_update | (branch & zero);

    // Reset presents FETCH selects with every enable held low, whatever the current state.
    if (rst) begin
      state_d    = S_FETCH;
      ALUOp      = ALUOP_ADD;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_FOUR;
      ResultSrc  = RES_ALURES;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      pc_write   = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;
    end

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: spec-level phase model checked every cycle, plus
// directed scenarios with hand-computed latencies and counter values.
module tb_main_fsm;
  localparam int CNT_W = 4;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, zero, mem_ready;
  logic [6:0]       op;
  logic [1:0]       ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic             AdrSrc, IRWrite, RegWrite, MemWrite, pc_write, illegal_op;
  logic [CNT_W-1:0] retired;
  logic [3:0]       dbg_state;

  main_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .pc_write(pc_write), .illegal_op(illegal_op), .retired(retired),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  string            ph = "FETCH";
  int               m_cnt = 0;
  bit               cmp_en = 0;

  always @(posedge clk) begin
    cmp_en = 1;
    if (rst) begin
      ph    = "FETCH";
      m_cnt = 0;
    end else begin
      case (ph)
        "FETCH":    if (mem_ready) ph = "DECODE";
        "DECODE": begin
          if (op == LW || op == SW) ph = "MEMADR";
          else if (op == RT)        ph = "EXECUTER";
          else if (op == IT)        ph = "EXECUTEI";
          else if (op == BEQ)       ph = "BEQ";
          else if (op == JAL)       ph = "JAL";
          else                      ph = "FETCH";
        end
        "MEMADR":   ph = (op == SW) ? "MEMWRITE" : "MEMREAD";
        "MEMREAD":  if (mem_ready) ph = "MEMWB";
        "MEMWB":    begin ph = "FETCH"; m_cnt = (m_cnt + 1) % (1 << CNT_W); end
        "MEMWRITE": if (mem_ready) begin ph = "FETCH"; m_cnt = (m_cnt + 1) % (1 << CNT_W); end
        "EXECUTER", "EXECUTEI", "JAL": ph = "ALUWB";
        "ALUWB", "BEQ": begin ph = "FETCH"; m_cnt = (m_cnt + 1) % (1 << CNT_W); end
        default:    ph = "FETCH";
      endcase
    end
  end

  logic [1:0] e_aluop, e_a, e_b, e_rs;
  logic       e_adr, e_ir, e_rw, e_mw, e_pc, e_ill;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_aluop = 2'b00; e_a = 2'b00; e_b = 2'b00; e_rs = 2'b00;
      e_adr = 0; e_ir = 0; e_rw = 0; e_mw = 0; e_pc = 0; e_ill = 0;
      if (rst) begin
        e_b = 2'b10; e_rs = 2'b10;
      end else begin
        case (ph)
          "FETCH":    begin e_b = 2'b10; e_rs = 2'b10; e_ir = mem_ready; e_pc = mem_ready; end
          "DECODE":   begin
            e_a = 2'b01; e_b = 2'b01;
            e_ill = !(op == LW || op == SW || op == RT || op == IT || op == BEQ || op == JAL);
          end
          "MEMADR":   begin e_a = 2'b10; e_b = 2'b01; end
          "MEMREAD":  e_adr = 1;
          "MEMWB":    begin e_rs = 2'b01; e_rw = 1; end
          "MEMWRITE": begin e_adr = 1; e_mw = 1; end
          "EXECUTER": begin e_a = 2'b10; e_aluop = 2'b10; end
          "EXECUTEI": begin e_a = 2'b10; e_b = 2'b01; e_aluop = 2'b10; end
          "JAL":      begin e_a = 2'b01; e_b = 2'b10; e_pc = 1; end
          "ALUWB":    e_rw = 1;
          "BEQ":      begin e_a = 2'b10; e_aluop = 2'b01; e_pc = zero; end
          default:    ;
        endcase
      end
      check({"m_aluop_", ph}, ALUOp, e_aluop);
      check({"m_srca_", ph}, ALUSrcA, e_a);
      check({"m_srcb_", ph}, ALUSrcB, e_b);
      check({"m_ressrc_", ph}, ResultSrc, e_rs);
      check({"m_adrsrc_", ph}, AdrSrc, e_adr);
      check({"m_irwrite_", ph}, IRWrite, e_ir);
      check({"m_regwrite_", ph}, RegWrite, e_rw);
      check({"m_memwrite_", ph}, MemWrite, e_mw);
      check({"m_pcwrite_", ph}, pc_write, e_pc);
      check({"m_illegal_", ph}, illegal_op, e_ill);
      check({"m_retired_", ph}, retired, m_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input logic r, input logic [6:0] o, input logic z, input logic m);
    rst = r; op = o; zero = z; mem_ready = m;
    #1;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] op_tab [7] = '{LW, SW, RT, IT, BEQ, JAL, BAD};

  initial begin
    // reset, two cycles
    apply(1, RT, 0, 1);
    check("rst_irwrite", IRWrite, 0);
    check("rst_pcwrite", pc_write, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_memwrite", MemWrite, 0);
    tick(2);
    apply(0, SW, 0, 1);
    check("rst_retired", retired, 0);
    check("fetch_irwrite", IRWrite, 1);

    // sw stalls in MEMWRITE, then reset mid-wait
    tick(3);
    apply(0, SW, 0, 0);
    check("sw_wait_mw1", MemWrite, 1);
    tick();
    check("sw_wait_mw2", MemWrite, 1);
    tick();
    apply(1, SW, 0, 0);
    check("sw_rst_mw", MemWrite, 0);
    tick();
    apply(0, RT, 0, 1);
    check("sw_rst_retired", retired, 0);
    check("sw_rst_fetch_srcb", ALUSrcB, 2);

    // R-type, 4 cycles
    tick(2);
    check("r_aluop", ALUOp, 2);
    tick();
    check("r_regwrite", RegWrite, 1);
    check("r_retired_pre", retired, 0);
    tick();
    check("r_retired", retired, 1);

    // lw with two MEMREAD wait cycles, 7 cycles total
    apply(0, LW, 0, 1);
    tick(3);
    apply(0, LW, 0, 0);
    check("lw_adrsrc", AdrSrc, 1);
    tick(2);
    apply(0, LW, 0, 1);
    check("lw_adrsrc_held", AdrSrc, 1);
    tick();
    check("lw_ressrc", ResultSrc, 1);
    check("lw_regwrite", RegWrite, 1);
    tick();
    check("lw_retired", retired, 2);

    // beq taken and not taken, 3 cycles each
    apply(0, BEQ, 1, 1);
    tick(2);
    check("beq_aluop", ALUOp, 1);
    check("beq_taken_pcw", pc_write, 1);
    tick();
    check("beq_taken_retired", retired, 3);
    apply(0, BEQ, 0, 1);
    tick(2);
    check("beq_nt_pcw", pc_write, 0);
    tick();
    check("beq_nt_retired", retired, 4);

    // illegal opcode
    apply(0, BAD, 0, 1);
    tick();
    check("ill_pulse", illegal_op, 1);
    tick();
    check("ill_clear", illegal_op, 0);
    check("ill_back_fetch", IRWrite, 1);
    check("ill_retired", retired, 4);

    // jal, I-type, sw without waits: 4 cycles each
    apply(0, JAL, 0, 1);
    tick(2);
    check("jal_pcw", pc_write, 1);
    check("jal_srca", ALUSrcA, 1);
    tick(2);
    check("jal_retired", retired, 5);
    apply(0, IT, 0, 1);
    tick(4);
    check("i_retired", retired, 6);
    apply(0, SW, 0, 1);
    tick(4);
    check("sw_retired", retired, 7);

    // counter wrap at 2^CNT_W
    for (int k = 0; k < 8; k++) begin
      apply(0, BEQ, 0, 1);
      tick(3);
    end
    check("wrap_pre", retired, 15);
    apply(0, BEQ, 0, 1);
    tick(3);
    check("wrap_zero", retired, 0);

    // mixed traffic with random stalls, checked by the model
    for (int k = 0; k < 300; k++) begin
      if (ph == "FETCH")
        apply(0, op_tab[$urandom_range(0, 6)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        apply(0, op, zero, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
